spi_stm32_xfer_seq: RTL and testbench
=====================================

// Module: spi_stm32_xfer_seq
// PURPOSE
//  Burst sequencer for the 16-bit STM32 SPI master. Accepts one command (word count, keep-SS flag), streams TX words
//  from an upstream valid/ready source into the master's register port and returns each RX word on a valid/ready sink.
//  Holds SS_n low across the whole burst via the control-register SSO bit. Sits between the NIOS/bridge logic and the
//  SPI master; it is the master's only register-port bus owner.
// PARAMETERS
//  DATA_W        16    SPI word width; equals master DATABITS
//  LEN_W         8     command length field; burst = cmd_len+1 words (1..256)
//  TIMEOUT_CYC   4096  watchdog limit per wait state (used only with SPI_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1       system clock (100 MHz)
//  reset_n        in   1       asynchronous active-low reset
//  cmd_valid      in   1       command offered
//  cmd_ready      out  1       high only in IDLE
//  cmd_len        in   LEN_W   words minus one
//  cmd_keep_ss    in   1       1: leave SSO set after burst (chained bursts)
//  tx_valid       in   1       TX word offered
//  tx_ready       out  1       TX word taken (1-cycle, in WR_DATA first cycle)
//  tx_data        in   DATA_W  TX word
//  rx_valid       out  1       RX word held until rx_ready
//  rx_ready       in   1       downstream accepts RX word
//  rx_data        out  DATA_W  RX word
//  done           out  1       1-cycle pulse at burst end
//  err            out  1       valid with done; 1 = aborted by watchdog (always 0 without macro)
//  busy           out  1       state != IDLE
//  spi_select     out  1       master chip select
//  spi_mem_addr   out  3       master register address
//  spi_read_n     out  1       master read strobe, active low
//  spi_write_n    out  1       master write strobe, active low
//  spi_wdata      out  DATA_W  master data_from_cpu
//  spi_rdata      in   DATA_W  master data_to_cpu
//  spi_readyfordata in 1       master TRDY
//  spi_dataavailable in 1      master RRDY
// BEHAVIOUR
//  - Reset: IDLE; cmd_ready=1; all other outputs 0 except spi_read_n=spi_write_n=1; counters/regs 0.
//  - Bus access = exactly 2 cycles select+strobe low, addr/wdata stable, then >=1 cycle all released. Never hold a
//    strobe 3 cycles (master re-triggers). Read data sampled from spi_rdata at end of 2nd access cycle.
//  - States: IDLE -> SS_ON (write addr3=0x0400) -> WAIT_T -> WR_DATA (write addr1=tx_data) -> WAIT_R ->
//    RD_DATA (read addr0) -> RX_PUSH -> [cnt!=0: cnt--, WAIT_T] / [cnt==0: keep_ss ? FIN : SS_OFF] ;
//    SS_OFF (write addr3=0x0000) -> FIN ; FIN: done=1 one cycle -> IDLE.
//  - IDLE: cmd accepted on cmd_valid&cmd_ready; latch cnt=cmd_len, keep_ss. SS_ON skipped if SSO already set by a
//    previous keep_ss burst (internal sso_q flag mirrors last control write).
//  - WAIT_T: leave when spi_readyfordata=1 and tx_valid=1; tx_ready pulses on WR_DATA first cycle, word latched.
//  - WAIT_R: leave when spi_dataavailable=1. One word in flight; no overlap of TX with pending RX.
//  - RX_PUSH: rx_data/rx_valid held stable until rx_ready; rx_valid&rx_ready completes the word. rx_ready high in the
//    same cycle rx_valid rises = zero-stall.
//  - Control writes write only SSO (bit10); all IRQ enables stay 0; status register never written.
//  - cmd_valid while busy ignored (cmd_ready=0). tx_valid outside WAIT_T ignored. cnt wrap impossible (stops at 0).
//  - Async reset mid-burst: immediate IDLE, strobes released; SS_n recovers because master shares reset_n.
//  - Per-word latency min: 3 (WR) + SPI frame (34 states x 7 clk = 238) + 3 (RD) + 1 push.
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined: 12-bit-or-wider watchdog counts cycles in WAIT_T/WAIT_R/RX_PUSH, cleared on state
//    change; at TIMEOUT_CYC -> SS_OFF (even if keep_ss) -> FIN with err=1; remaining TX words not consumed.
//  Not defined: no counter logic, waits are unbounded, err tied 0.
// TESTING
//  1. cmd_len=0, keep_ss=0, tx 0xA55A, MISO loopback -> writes 0x0400@3, 0xA55A@1, read @0, rx_data=0xA55A, 0x0000@3, done, err=0.
//  2. cmd_len=3, tx 0x0001..0x0004, rx_ready low 50 cycles on word 2 -> 4 rx words in order, SS_n low continuously, no extra bus writes.
//  3. burst A keep_ss=1 then burst B keep_ss=0 -> one 0x0400 write total, SS_n low across both, one 0x0000 write at end.
//  4. reset_n low during 3rd WAIT_R of cmd_len=7 -> next cycle busy=0, strobes 1, SS_n=1; new cmd then runs cleanly.
//  5. bus checker: every access exactly 2 strobe cycles + idle gap; cmd_valid during busy never accepted.
//  6. SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64, tx_valid held 0 -> after 64 cycles 0x0000@3, done=1, err=1; without macro stays busy.

Source files
------------

// File: rtl/spi_stm32_xfer_seq.sv
// Burst sequencer owning the STM32 SPI master register port: SSO control, TX word writes, RX word reads.
// Optional per-wait-state watchdog is built when SPI_SEQ_TIMEOUT_EN is defined.
module spi_stm32_xfer_seq #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_keep_ss,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              spi_select,
  output logic [2:0]        spi_mem_addr,
  output logic              spi_read_n,
  output logic              spi_write_n,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic [DATA_W-1:0] spi_rdata,
  input  logic              spi_readyfordata,
  input  logic              spi_dataavailable
);

  localparam logic [DATA_W-1:0] SSO_WORD = DATA_W'(32'h0000_0400);

  typedef enum logic [3:0] {
    S_IDLE, S_SS_ON, S_WAIT_T, S_WR_DATA, S_WAIT_R, S_RD_DATA, S_RX_PUSH, S_SS_OFF, S_FIN
  } state_t;

  state_t             state, state_n;
  logic [1:0]         phase;
  logic [LEN_W-1:0]   cnt;
  logic               keep_q, sso_q, err_q;
  logic [DATA_W-1:0]  tx_q, rx_q;
  logic               acc_state, acc_active, acc_last;
  logic               progress, abort;

  // Every bus access is two strobe cycles (phase 0,1) plus one released gap cycle (phase 2).
  assign acc_state  = (state == S_SS_ON) || (state == S_WR_DATA) ||
                      (state == S_RD_DATA) || (state == S_SS_OFF);
  assign acc_active = acc_state && (phase != 2'd2);
  assign acc_last   = acc_state && (phase == 2'd2);

  assign progress = ((state == S_WAIT_T)  && spi_readyfordata && tx_valid) ||
                    ((state == S_WAIT_R)  && spi_dataavailable) ||
                    ((state == S_RX_PUSH) && rx_ready);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = ($clog2(TIMEOUT_CYC) > 12) ? $clog2(TIMEOUT_CYC) : 12;
  logic [WD_W-1:0] wd;
  logic            wait_state;

  assign wait_state = (state == S_WAIT_T) || (state == S_WAIT_R) || (state == S_RX_PUSH);
  assign abort      = wait_state && !progress && (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wd <= '0;
    else if (state_n != state) wd <= '0;
    else if (wait_state)       wd <= wd + WD_W'(1);
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (cmd_valid) state_n = sso_q ? S_WAIT_T : S_SS_ON;
      S_SS_ON:   if (acc_last) state_n = S_WAIT_T;
      S_WAIT_T:  if (progress) state_n = S_WR_DATA;
                 else if (abort) state_n = S_SS_OFF;
      S_WR_DATA: if (acc_last) state_n = S_WAIT_R;
      S_WAIT_R:  if (progress) state_n = S_RD_DATA;
                 else if (abort) state_n = S_SS_OFF;
      S_RD_DATA: if (acc_last) state_n = S_RX_PUSH;
      S_RX_PUSH: if (progress) begin
                   if (cnt != '0)  state_n = S_WAIT_T;
                   else if (keep_q) state_n = S_FIN;
                   else             state_n = S_SS_OFF;
                 end else if (abort) state_n = S_SS_OFF;
      S_SS_OFF:  if (acc_last) state_n = S_FIN;
      S_FIN:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      cnt    <= '0;
      keep_q <= 1'b0;
      sso_q  <= 1'b0;
      err_q  <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      if (state_n != state) phase <= '0;
      else if (acc_state)   phase <= phase + 2'd1;
      if ((state == S_IDLE) && cmd_valid) begin
        cnt    <= cmd_len;
        keep_q <= cmd_keep_ss;
        err_q  <= 1'b0;
      end
      if ((state == S_WAIT_T) && progress) tx_q <= tx_data;
      if ((state == S_RD_DATA) && (phase == 2'd1)) rx_q <= spi_rdata;
      if ((state == S_RX_PUSH) && rx_ready && (cnt != '0)) cnt <= cnt - LEN_W'(1);
      // sso_q mirrors the last control write so a chained burst can skip SS_ON
      if ((state == S_SS_ON)  && (phase == 2'd1)) sso_q <= 1'b1;
      if ((state == S_SS_OFF) && (phase == 2'd1)) sso_q <= 1'b0;
      if (abort) err_q <= 1'b1;
    end
  end

  always_comb begin
    cmd_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    done         = (state == S_FIN);
    err          = (state == S_FIN) && err_q;
    rx_valid     = (state == S_RX_PUSH);
    rx_data      = rx_q;
    tx_ready     = (state == S_WR_DATA) && (phase == 2'd0);
    spi_select   = 1'b0;
    spi_mem_addr = '0;
    spi_read_n   = 1'b1;
    spi_write_n  = 1'b1;
    spi_wdata    = '0;
    if (acc_active) begin
      spi_select = 1'b1;
      case (state)
        S_SS_ON: begin
          spi_mem_addr = 3'd3;
          spi_wdata    = SSO_WORD;
          spi_write_n  = 1'b0;
        end
        S_SS_OFF: begin
          spi_mem_addr = 3'd3;
          spi_write_n  = 1'b0;
        end
        S_WR_DATA: begin
          spi_mem_addr = 3'd1;
          spi_wdata    = tx_q;
          spi_write_n  = 1'b0;
        end
        default: begin
          spi_mem_addr = 3'd0;
          spi_read_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_stm32_xfer_seq.sv
// Bench for spi_stm32_xfer_seq: loopback SPI master model, bus-protocol checker, randomized bursts.
// Behaviour under SPI_SEQ_TIMEOUT_EN is checked when the macro is defined for the build.
module tb_spi_stm32_xfer_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_keep_ss = 1'b0;
  logic [7:0]  cmd_len = '0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [15:0] tx_data = '0;
  logic        rx_valid, rx_ready = 1'b0;
  logic [15:0] rx_data;
  logic        done, err, busy;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_wdata, spi_rdata;
  logic        spi_readyfordata, spi_dataavailable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_stm32_xfer_seq #(.DATA_W(16), .LEN_W(8), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_keep_ss(cmd_keep_ss),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .err(err), .busy(busy),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_readyfordata(spi_readyfordata), .spi_dataavailable(spi_dataavailable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // SPI master model: registers act on the second strobe cycle; TX word loops back to RX after a short frame.
  logic        m_sso, m_trdy, m_rrdy, m_shift, ss_n;
  logic [15:0] m_rx, m_sh;
  int          m_lat, wph, rph, rd_cnt;
  logic [2:0]  wa[$];
  logic [15:0] wd[$];

  assign spi_rdata         = m_rx;
  assign spi_readyfordata  = m_trdy;
  assign spi_dataavailable = m_rrdy;
  assign ss_n              = ~m_sso;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sso <= 1'b0; m_trdy <= 1'b1; m_rrdy <= 1'b0; m_shift <= 1'b0;
      m_rx <= '0; m_sh <= '0; m_lat <= 0; wph <= 0; rph <= 0;
    end else begin
      if (!spi_write_n) begin
        if (wph == 1) begin
          wa.push_back(spi_mem_addr);
          wd.push_back(spi_wdata);
          if (spi_mem_addr == 3'd3) m_sso <= spi_wdata[10];
          else if (spi_mem_addr == 3'd1) begin
            check("wr_while_trdy", 32'(m_trdy), 1);
            m_trdy <= 1'b0; m_shift <= 1'b1; m_sh <= spi_wdata; m_lat <= $urandom_range(3, 10);
          end
        end
        wph <= wph + 1;
      end else wph <= 0;
      if (!spi_read_n) begin
        if (rph == 1) begin
          rd_cnt <= rd_cnt + 1;
          m_rrdy <= 1'b0;
        end
        rph <= rph + 1;
      end else rph <= 0;
      if (m_shift) begin
        if (m_lat == 0) begin
          m_rx <= m_sh; m_rrdy <= 1'b1; m_trdy <= 1'b1; m_shift <= 1'b0;
        end else m_lat <= m_lat - 1;
      end
    end
  end

  // Bus checker: two strobe cycles with stable address/data, then a released cycle.
  int          blen = 0;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  always @(negedge clk) begin
    if (!reset_n) blen <= 0;
    else if (!spi_write_n || !spi_read_n) begin
      if (!spi_write_n && !spi_read_n) check("bus_both_strobes", 1, 0);
      if (blen == 0) begin
        b_addr <= spi_mem_addr;
        b_data <= spi_wdata;
        check("bus_select", 32'(spi_select), 1);
        if (!spi_read_n) check("rd_addr", 32'(spi_mem_addr), 0);
      end else if (blen == 1) begin
        check("bus_addr_stable", 32'(spi_mem_addr), 32'(b_addr));
        check("bus_data_stable", 32'(spi_wdata), 32'(b_data));
      end else check("bus_strobe_len", 32'(blen + 1), 2);
      blen <= blen + 1;
    end else begin
      if (blen != 0) begin
        check("bus_strobe_len", 32'(blen), 2);
        check("bus_release_sel", 32'(spi_select), 0);
      end
      blen <= 0;
    end
  end

  logic [2:0]  exp_wa[$];
  logic [15:0] exp_wd[$];
  int exp_rd = 0, wbase = 0, rbase = 0;
  bit exp_sso = 1'b0;

  task automatic check_log();
    check("wr_count", 32'(wa.size() - wbase), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size(); i++)
      if (wbase + i < wa.size()) begin
        check("wr_addr", 32'(wa[wbase + i]), 32'(exp_wa[i]));
        check("wr_data", 32'(wd[wbase + i]), 32'(exp_wd[i]));
      end
    check("rd_count", 32'(rd_cnt - rbase), 32'(exp_rd));
    exp_wa.delete(); exp_wd.delete();
    wbase = wa.size(); rbase = rd_cnt; exp_rd = 0;
  endtask

  task automatic issue_cmd(input int len, input bit keep);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = 8'(len); cmd_keep_ss = keep;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input int len, input bit keep, input bit fixed, input logic [15:0] w0,
                           input int stall_word);
    logic [15:0] txw[$];
    int n = len + 1;
    int tx_idx = 0, rx_idx = 0, cyc = 0, stall_left = -1;
    bit stall_done = 1'b0, seen = 1'b0;
    for (int i = 0; i < n; i++) txw.push_back(fixed ? w0 + 16'(i) : 16'($urandom));
    if (!exp_sso) begin exp_wa.push_back(3'd3); exp_wd.push_back(16'h0400); end
    exp_sso = 1'b1;
    for (int i = 0; i < n; i++) begin exp_wa.push_back(3'd1); exp_wd.push_back(txw[i]); end
    exp_rd += n;
    if (!keep) begin exp_wa.push_back(3'd3); exp_wd.push_back(16'h0000); exp_sso = 1'b0; end

    issue_cmd(len, keep);
    while (rx_idx < n && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (tx_valid && tx_ready) tx_idx++;
      if (rx_valid && rx_ready) begin
        check("rx_data", 32'(rx_data), 32'(txw[rx_idx]));
        rx_idx++;
      end
      if (busy && cmd_valid) check("cmd_ignored_busy", 32'(cmd_ready), 0);
      if (rx_idx == stall_word && rx_valid && !stall_done && stall_left < 0) stall_left = 50;
      if (rx_idx >= n) break;
      @(posedge clk); #1;
      tx_valid = (tx_idx < n) && (tx_valid || ($urandom_range(0, 3) == 0));
      if (tx_idx < n) tx_data = txw[tx_idx];
      if (stall_left > 0) begin
        stall_left--;
        rx_ready = 1'b0;
        if (stall_left == 0) begin
          check("rx_hold_valid", 32'(rx_valid), 1);
          check("rx_hold_data", 32'(rx_data), 32'(txw[rx_idx]));
          stall_done = 1'b1;
          rx_ready = 1'b1;
        end
      end else if (rx_idx == stall_word && !stall_done) rx_ready = 1'b0;
      else rx_ready = ($urandom_range(0, 9) < 7);
      cmd_valid = 1'($urandom_range(0, 1));
    end
    check("burst_words", 32'(rx_idx), 32'(n));
    check("tx_taken", 32'(tx_idx), 32'(n));
    @(posedge clk); #1;
    cmd_valid = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 32'(seen), 1);
    check("err_clear", 32'(err), 0);
    @(negedge clk);
    check("idle_after_done", 32'(busy), 0);
    check("ss_after_burst", 32'(ss_n), 32'(!keep));
  endtask

  initial begin
    int c;
    bit seen;
    rd_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_select", 32'(spi_select), 0);
    check("rst_read_n", 32'(spi_read_n), 1);
    check("rst_write_n", 32'(spi_write_n), 1);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_addr", 32'(spi_mem_addr), 0);
    check("rst_wdata", 32'(spi_wdata), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    run_burst(0, 1'b0, 1'b1, 16'hA55A, -1);
    check_log();
    run_burst(3, 1'b0, 1'b1, 16'h0001, 1);
    check_log();

    run_burst($urandom_range(0, 4), 1'b1, 1'b0, 16'h0, -1);
    check("ss_between_chained", 32'(ss_n), 0);
    run_burst($urandom_range(0, 4), 1'b0, 1'b0, 16'h0, -1);
    check_log();

    for (int k = 0; k < 4; k++) begin
      run_burst($urandom_range(0, 5), (k == 3) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, 16'h0, -1);
      check_log();
    end

    // Async reset while waiting on the third frame of an 8-word burst
    issue_cmd(7, 1'b0);
    tx_valid = 1'b1; tx_data = 16'h1234; rx_ready = 1'b1;
    c = 0;
    while ((wa.size() - wbase) < 4 && c < 2000) begin @(negedge clk); c++; end
    check("reach_third_wr", 32'(wa.size() - wbase), 4);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_write_n", 32'(spi_write_n), 1);
    check("mid_rst_read_n", 32'(spi_read_n), 1);
    check("mid_rst_select", 32'(spi_select), 0);
    check("mid_rst_ss_n", 32'(ss_n), 1);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_sso = 1'b0; exp_wa.delete(); exp_wd.delete();
    wbase = wa.size(); rbase = rd_cnt; exp_rd = 0;
    run_burst(2, 1'b0, 1'b0, 16'h0, -1);
    check_log();

    // TX source starves: watchdog abort when built in, otherwise the sequencer waits indefinitely
    issue_cmd(0, 1'b0);
    exp_wa.push_back(3'd3); exp_wd.push_back(16'h0400);
    c = 0; seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done && !seen) begin
        seen = 1'b1; c = i;
        check("timeout_err", 32'(err), 1);
      end
    end
`ifdef SPI_SEQ_TIMEOUT_EN
    check("timeout_done", 32'(seen), 1);
    check("timeout_window", 32'(c >= 66 && c <= 76), 1);
    check("timeout_ss_n", 32'(ss_n), 1);
    exp_wa.push_back(3'd3); exp_wd.push_back(16'h0000);
    check_log();
`else
    check("no_timeout_done", 32'(seen), 0);
    check("no_timeout_busy", 32'(busy), 1);
    check_log();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wbase = wa.size(); rbase = rd_cnt;
`endif
    exp_sso = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
